// File: rtl/mbx_ombx_reader.sv
// Outbound mailbox reader: walks an object out of SRAM one DWORD at a time,
// presents each word on the system RDATA path and waits for it to be consumed.
//
//   state | meaning
//   IDLE  | waiting for the mailbox FSM to enter READ
//   REQ   | memory request outstanding, waiting for grant (limit checked here)
//   WAIT  | granted, waiting for read data
//   HOLD  | word presented on read_data_o until the system reads it
//   DRAIN | aborted after grant; swallow the pending rvalid
//   ERR   | limit overrun; parked until the mailbox is cleared
module mbx_ombx_reader (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mbx_read_i,
    input  logic        mbx_clear_i,
    input  logic        mbx_range_valid_i,
    input  logic [31:0] sram_base_addr_i,
    input  logic [31:0] sram_limit_addr_i,
    input  logic [10:0] object_size_i,
    input  logic        sysif_read_i,
    input  logic        sram_gnt_i,
    input  logic        sram_rvalid_i,
    input  logic [31:0] sram_rdata_i,
    output logic        sram_req_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] read_data_o,
    output logic        read_data_valid_o,
    output logic        sys_read_all_o,
    output logic        read_error_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_read_ptr;
    logic [10:0] r_remaining;
    logic [31:0] r_data;
    logic        r_armed;
    logic        r_all;

    logic        w_over;
    logic        w_load;
    logic        w_capture;
    logic        w_all_set;

    // The pointer is compared against the limit while sitting in REQ, so an
    // overrun never produces a request on the bus.
    assign w_over = (r_read_ptr > sram_limit_addr_i);

    // Next-state decode; mbx_clear_i is evaluated ahead of every other input
    // except in DRAIN, which must always wait for its outstanding rvalid.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_all_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!mbx_clear_i && mbx_read_i && mbx_range_valid_i && r_armed) begin
                    w_load = 1'b1;
                    if (object_size_i == 11'd0) begin
                        w_all_set = 1'b1;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mbx_clear_i) begin
                    w_next = (sram_gnt_i && !w_over) ? S_DRAIN : S_IDLE;
                end else if (w_over) begin
                    w_next = S_ERR;
                end else if (sram_gnt_i) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sram_rvalid_i) begin
                    if (mbx_clear_i) begin
                        w_next = S_IDLE;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = S_HOLD;
                    end
                end else if (mbx_clear_i) begin
                    w_next = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (mbx_clear_i) begin
                    w_next = S_IDLE;
                end else if (sysif_read_i) begin
                    if (r_remaining == 11'd0) begin
                        w_all_set = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (sram_rvalid_i) begin
                    w_next = S_IDLE;
                end
            end
            S_ERR: begin
                if (mbx_clear_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset drops any outstanding request without draining.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pointer, word counter and data register; data is cleared once the word
    // leaves HOLD so stale words never linger.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_read_ptr  <= 32'd0;
            r_remaining <= 11'd0;
            r_data      <= 32'd0;
        end else begin
            if (w_load) begin
                r_read_ptr  <= sram_base_addr_i;
                r_remaining <= object_size_i;
            end else if (w_capture) begin
                r_read_ptr  <= r_read_ptr + 32'd4;
                r_remaining <= r_remaining - 11'd1;
            end
            if (w_capture) begin
                r_data <= sram_rdata_i;
            end else if (r_state == S_HOLD && w_next != S_HOLD) begin
                r_data <= 32'd0;
            end
        end
    end

    // Completion pulse, and the re-arm flag that blocks a restart until the
    // mailbox FSM has left READ at least once after a completed object.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_all   <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_all <= w_all_set;
            if (w_all_set) begin
                r_armed <= 1'b0;
            end else if (!mbx_read_i) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign sram_req_o        = (r_state == S_REQ) && !w_over;
    assign sram_addr_o       = sram_req_o ? r_read_ptr : 32'd0;
    assign read_data_valid_o = (r_state == S_HOLD);
    assign read_data_o       = read_data_valid_o ? r_data : 32'd0;
    assign sys_read_all_o    = r_all;
    assign read_error_o      = (r_state == S_REQ) && w_over && !mbx_clear_i;
    assign busy_o            = (r_state != S_IDLE);

endmodule

// File: tb/tb_mbx_ombx_reader.sv
// Bench for the outbound mailbox reader: acts as SRAM and system side,
// checking against an address/data model derived from base, limit and size.
module tb_mbx_ombx_reader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mbx_read_i = 1'b0;
    logic        mbx_clear_i = 1'b0;
    logic        mbx_range_valid_i = 1'b0;
    logic [31:0] sram_base_addr_i = 32'd0;
    logic [31:0] sram_limit_addr_i = 32'd0;
    logic [10:0] object_size_i = 11'd0;
    logic        sysif_read_i = 1'b0;
    logic        sram_gnt_i = 1'b0;
    logic        sram_rvalid_i = 1'b0;
    logic [31:0] sram_rdata_i = 32'd0;
    logic        sram_req_o;
    logic [31:0] sram_addr_o;
    logic [31:0] read_data_o;
    logic        read_data_valid_o;
    logic        sys_read_all_o;
    logic        read_error_o;
    logic        busy_o;

    int n_total = 0;
    int n_pass  = 0;

    mbx_ombx_reader dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .mbx_read_i        (mbx_read_i),
        .mbx_clear_i       (mbx_clear_i),
        .mbx_range_valid_i (mbx_range_valid_i),
        .sram_base_addr_i  (sram_base_addr_i),
        .sram_limit_addr_i (sram_limit_addr_i),
        .object_size_i     (object_size_i),
        .sysif_read_i      (sysif_read_i),
        .sram_gnt_i        (sram_gnt_i),
        .sram_rvalid_i     (sram_rvalid_i),
        .sram_rdata_i      (sram_rdata_i),
        .sram_req_o        (sram_req_o),
        .sram_addr_o       (sram_addr_o),
        .read_data_o       (read_data_o),
        .read_data_valid_o (read_data_valid_o),
        .sys_read_all_o    (sys_read_all_o),
        .read_error_o      (read_error_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Memory contents as a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Number of words of the object lying at or below the inclusive limit.
    function automatic int words_in_limit(input logic [31:0] base, input logic [31:0] limit,
                                          input logic [10:0] size);
        int n = 0;
        for (int i = 0; i < int'(size); i++) begin
            if (base + 32'(4 * i) <= limit) n++;
            else break;
        end
        return n;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   {31'd0, sram_req_o}, 32'd0);
        check({tag, "_addr"},  sram_addr_o, 32'd0);
        check({tag, "_rdata"}, read_data_o, 32'd0);
        check({tag, "_rdv"},   {31'd0, read_data_valid_o}, 32'd0);
        check({tag, "_all"},   {31'd0, sys_read_all_o}, 32'd0);
        check({tag, "_err"},   {31'd0, read_error_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    endtask

    // Run one object: the bench plays SRAM (grant after gnt_dly request cycles,
    // rvalid rv_dly cycles after grant) and system (read after sys_dly cycles).
    task automatic run_obj(input logic [31:0] base, input logic [31:0] limit,
                           input logic [10:0] size, input int gnt_dly, input int rv_dly,
                           input int sys_dly, input string tag);
        int exp_n, granted, consumed, all_cnt, err_cnt, req_cyc, rv_cnt, hold_cyc, tail;
        bit exp_err, req_open, done;
        logic [31:0] gaddr;
        exp_n   = words_in_limit(base, limit, size);
        exp_err = (exp_n < int'(size));
        granted = 0; consumed = 0; all_cnt = 0; err_cnt = 0;
        req_cyc = 0; rv_cnt = 0; hold_cyc = 0; tail = 0;
        req_open = 1'b0; done = 1'b0; gaddr = 32'd0;
        @(negedge clk_i);
        sram_base_addr_i  = base;
        sram_limit_addr_i = limit;
        object_size_i     = size;
        mbx_range_valid_i = 1'b1;
        mbx_read_i        = 1'b1;
        for (int cyc = 0; cyc < 400 && tail < 4; cyc++) begin
            @(negedge clk_i);
            sram_gnt_i    = 1'b0;
            sram_rvalid_i = 1'b0;
            sysif_read_i  = 1'b0;
            if (done) tail++;
            if (!read_data_valid_o) begin
                check({tag, "_rdata_zero"}, read_data_o, 32'd0);
                sysif_read_i = 1'($urandom_range(0, 1));
            end
            if (rv_cnt > 0) begin
                check({tag, "_no_req_in_wait"}, {31'd0, sram_req_o}, 32'd0);
                rv_cnt--;
                if (rv_cnt == 0) begin
                    sram_rvalid_i = 1'b1;
                    sram_rdata_i  = mem_word(gaddr);
                end
            end else if (sram_req_o) begin
                check({tag, "_addr"}, sram_addr_o, base + 32'(4 * granted));
                if (req_cyc == gnt_dly) begin
                    sram_gnt_i = 1'b1;
                    gaddr      = sram_addr_o;
                    granted++;
                    rv_cnt   = rv_dly;
                    req_cyc  = 0;
                    req_open = 1'b0;
                end else begin
                    req_cyc++;
                    req_open = 1'b1;
                end
            end else if (req_open) begin
                check({tag, "_req_held"}, {31'd0, sram_req_o}, 32'd1);
                req_open = 1'b0;
            end else begin
                sram_rvalid_i = 1'($urandom_range(0, 1));
                sram_rdata_i  = $urandom;
            end
            if (read_data_valid_o) begin
                check({tag, "_data"}, read_data_o, mem_word(base + 32'(4 * consumed)));
                if (hold_cyc == sys_dly) begin
                    sysif_read_i = 1'b1;
                    consumed++;
                    hold_cyc = 0;
                end else begin
                    hold_cyc++;
                end
            end
            if (sys_read_all_o) begin
                all_cnt++;
                done = 1'b1;
            end
            if (read_error_o) begin
                err_cnt++;
                check({tag, "_no_req_on_err"}, {31'd0, sram_req_o}, 32'd0);
                done = 1'b1;
            end
        end
        sram_gnt_i    = 1'b0;
        sram_rvalid_i = 1'b0;
        sysif_read_i  = 1'b0;
        check({tag, "_done"},     {31'd0, done}, 32'd1);
        check({tag, "_words"},    32'(consumed), 32'(exp_n));
        check({tag, "_granted"},  32'(granted), 32'(exp_n));
        check({tag, "_all_cnt"},  32'(all_cnt), exp_err ? 32'd0 : 32'd1);
        check({tag, "_err_cnt"},  32'(err_cnt), exp_err ? 32'd1 : 32'd0);
        if (exp_err) begin
            check({tag, "_err_busy"}, {31'd0, busy_o}, 32'd1);
            check({tag, "_err_req"},  {31'd0, sram_req_o}, 32'd0);
            check({tag, "_err_rdv"},  {31'd0, read_data_valid_o}, 32'd0);
            check({tag, "_err_perr"}, {31'd0, read_error_o}, 32'd0);
            mbx_clear_i = 1'b1;
            mbx_read_i  = 1'b0;
            @(negedge clk_i);
            mbx_clear_i = 1'b0;
        end else begin
            mbx_read_i = 1'b0;
            @(negedge clk_i);
        end
        check({tag, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic g;
        // Reset state
        #2;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("post_reset");

        // Directed scenarios
        run_obj(32'h1000, 32'h0000_FFFF, 11'd3, 0, 1, 1, "three_word");
        run_obj(32'h1800, 32'h0000_FFFF, 11'd0, 0, 1, 0, "size_zero");
        run_obj(32'h2000, 32'h0000_2004, 11'd3, 0, 1, 0, "overrun");
        run_obj(32'h2400, 32'h0000_FFFF, 11'd2, 4, 2, 2, "gnt_delay4");

        // Clear in the grant cycle, rvalid three cycles later
        @(negedge clk_i);
        sram_base_addr_i  = 32'h3000;
        sram_limit_addr_i = 32'h0000_FFFF;
        object_size_i     = 11'd2;
        mbx_read_i        = 1'b1;
        for (int i = 0; i < 10 && !sram_req_o; i++) @(negedge clk_i);
        check("clr_req_seen", {31'd0, sram_req_o}, 32'd1);
        sram_gnt_i  = 1'b1;
        mbx_clear_i = 1'b1;
        mbx_read_i  = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            sram_gnt_i  = 1'b0;
            mbx_clear_i = 1'b0;
            check("drain_rdv",  {31'd0, read_data_valid_o}, 32'd0);
            check("drain_busy", {31'd0, busy_o}, 32'd1);
            check("drain_req",  {31'd0, sram_req_o}, 32'd0);
            if (k == 3) begin
                sram_rvalid_i = 1'b1;
                sram_rdata_i  = 32'hDEAD_BEEF;
            end
        end
        @(negedge clk_i);
        sram_rvalid_i = 1'b0;
        check("drain_done_busy", {31'd0, busy_o}, 32'd0);
        check("drain_done_rdv",  {31'd0, read_data_valid_o}, 32'd0);
        check("drain_done_data", read_data_o, 32'd0);

        // Clear in REQ without grant drops the request
        mbx_read_i = 1'b1;
        for (int i = 0; i < 10 && !sram_req_o; i++) @(negedge clk_i);
        check("clr_req2_seen", {31'd0, sram_req_o}, 32'd1);
        mbx_clear_i = 1'b1;
        mbx_read_i  = 1'b0;
        @(negedge clk_i);
        mbx_clear_i = 1'b0;
        check("clr_req_idle", {31'd0, busy_o}, 32'd0);
        check("clr_req_dropped", {31'd0, sram_req_o}, 32'd0);

        // Reset asserted in HOLD
        @(negedge clk_i);
        sram_base_addr_i = 32'h4000;
        object_size_i    = 11'd2;
        mbx_read_i       = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            sram_gnt_i    = 1'b0;
            sram_rvalid_i = g;
            if (g) sram_rdata_i = mem_word(32'h4000);
            g = 1'b0;
            if (read_data_valid_o) break;
            if (sram_req_o) begin
                sram_gnt_i = 1'b1;
                g = 1'b1;
            end
        end
        check("rst_hold_reached", {31'd0, read_data_valid_o}, 32'd1);
        check("rst_hold_data", read_data_o, mem_word(32'h4000));
        rst_i      = 1'b1;
        mbx_read_i = 1'b0;
        #1;
        check_idle_outputs("rst_in_hold");
        @(negedge clk_i);
        rst_i = 1'b0;
        run_obj(32'h5000, 32'h0000_FFFF, 11'd2, 1, 2, 1, "after_reset");

        // Randomized objects, some of which overrun their limit
        for (int n = 0; n < 8; n++) begin
            logic [31:0] b;
            logic [31:0] l;
            b = 32'h6000 + 32'($urandom_range(0, 255) * 4);
            l = b + 32'($urandom_range(0, 7) * 4);
            run_obj(b, l, 11'($urandom_range(1, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
